// File: rtl/wavelet_channel_sequencer.sv
// -----------------------------------------------------------------------------
// wavelet_channel_sequencer
//
// Time-multiplexes one wavelet filter engine across NUM_CH channels. A pad
// strobe (i_data_clk, asynchronous to clk) is synchronised. Its rising edge
// captures one sample and the channel enable mask. The enabled channels are
// then started one after another in ascending index order. Each channel waits
// for the engine's completion pulse, or for a bounded timeout, before the next
// channel is started. A frame-done pulse closes the frame.
//
// Ports
//   clk              sole clock
//   rst              synchronous active-high reset
//   i_data_clk       asynchronous sample strobe from the pad
//   i_value          pad sample data (DATA_W)
//   i_enable_mask    per-channel enable, bit n = process channel n (NUM_CH)
//   i_ch_done        one-cycle completion pulse from the filter engine
//   i_clear_overrun  clears the sticky overrun and timeout flags
//   o_sample         sample captured at the accepted strobe edge (DATA_W)
//   o_ch_index       channel currently scheduled (CH_W)
//   o_ch_start       one-cycle start pulse to the engine
//   o_frame_done     one-cycle pulse at the end of a frame
//   o_active         high whenever the sequencer is not idle
//   o_overrun        sticky: a strobe edge arrived while busy and was dropped
//   o_timeout        sticky: a channel never reported completion
//
// CH_W must equal $clog2(NUM_CH).
// -----------------------------------------------------------------------------
module wavelet_channel_sequencer #(
  parameter int DATA_W  = 8,
  parameter int NUM_CH  = 8,
  parameter int CH_W    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_data_clk,
  input  logic [DATA_W-1:0] i_value,
  input  logic [NUM_CH-1:0] i_enable_mask,
  input  logic              i_ch_done,
  input  logic              i_clear_overrun,
  output logic [DATA_W-1:0] o_sample,
  output logic [CH_W-1:0]   o_ch_index,
  output logic              o_ch_start,
  output logic              o_frame_done,
  output logic              o_active,
  output logic              o_overrun,
  output logic              o_timeout
);

  // The WAIT timer only has to reach TIMEOUT-1.
  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Return {found, index} for the lowest set bit of mask. When above is set,
  // only bits strictly above cur are considered, so the index never wraps.
  function automatic logic [CH_W:0] pick_ch(input logic [NUM_CH-1:0] mask,
                                            input logic [CH_W-1:0]   cur,
                                            input logic              above);
    logic [CH_W:0] res;
    res = '0;
    // Scan downwards so the last hit is the lowest qualifying bit.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (!above || (i > int'(cur)))) begin
        res = {1'b1, CH_W'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Registers
  logic              sync1_q, sync2_q, sync3_q;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              ch_start_q;
  logic              frame_done_q;
  logic              active_q;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  // Combinational helpers
  logic              edge_s;
  logic              overrun_set_s;
  logic              timeout_set_s;
  logic [CH_W:0]     pick_s;

  // Next-state and datapath decode for the sequencer.
  always_comb begin
    edge_s        = sync2_q & ~sync3_q;
    state_d       = state_q;
    sample_d      = sample_q;
    mask_d        = mask_q;
    ch_idx_d      = ch_idx_q;
    timer_d       = timer_q;
    timeout_set_s = 1'b0;
    pick_s        = '0;

    case (state_q)
      ST_IDLE: begin
        if (edge_s) begin
          sample_d = i_value;
          mask_d   = i_enable_mask;
          pick_s   = pick_ch(i_enable_mask, ch_idx_q, 1'b0);
          if (pick_s[CH_W]) begin
            state_d  = ST_START;
            ch_idx_d = pick_s[CH_W-1:0];
          end else begin
            // Empty mask: close the frame without touching the engine.
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end

      ST_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (i_ch_done) begin
          // Completion beats a simultaneous expiry.
          state_d = ST_NEXT;
        end else if (timer_q == TMR_LAST) begin
          timeout_set_s = 1'b1;
          state_d       = ST_NEXT;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_NEXT: begin
        pick_s = pick_ch(mask_q, ch_idx_q, 1'b1);
        if (pick_s[CH_W]) begin
          state_d  = ST_START;
          ch_idx_d = pick_s[CH_W-1:0];
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Edges outside IDLE are dropped and flagged; a set beats a clear.
    overrun_set_s = edge_s & (state_q != ST_IDLE);

    if (overrun_set_s) begin
      overrun_d = 1'b1;
    end else if (i_clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (timeout_set_s) begin
      timeout_d = 1'b1;
    end else if (i_clear_overrun) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Chain loads ones so a strobe held high through reset is not an edge.
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      sync3_q      <= 1'b1;
      state_q      <= ST_IDLE;
      sample_q     <= '0;
      mask_q       <= '0;
      ch_idx_q     <= '0;
      timer_q      <= '0;
      ch_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      active_q     <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      sync1_q      <= i_data_clk;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      state_q      <= state_d;
      sample_q     <= sample_d;
      mask_q       <= mask_d;
      ch_idx_q     <= ch_idx_d;
      timer_q      <= timer_d;
      // START and DONE last exactly one cycle, so these are single pulses.
      ch_start_q   <= (state_d == ST_START);
      frame_done_q <= (state_d == ST_DONE);
      active_q     <= (state_d != ST_IDLE);
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_sample     = sample_q;
  assign o_ch_index   = ch_idx_q;
  assign o_ch_start   = ch_start_q;
  assign o_frame_done = frame_done_q;
  assign o_active     = active_q;
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_wavelet_channel_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for wavelet_channel_sequencer.
//
// A frame-level reference model runs alongside the DUT. At capture it turns
// the mask into a queue of channels. It counts WAIT cycles toward the timeout
// and keeps the sticky flags. Every cycle all DUT outputs are compared with
// it. Directed scenarios add literal expectations on latency, channel order,
// timeout distance and flag behaviour.
// -----------------------------------------------------------------------------
module tb_wavelet_channel_sequencer;

  localparam int DATA_W  = 8;
  localparam int NUM_CH  = 8;
  localparam int CH_W    = 3;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_data_clk;
  logic [DATA_W-1:0] i_value;
  logic [NUM_CH-1:0] i_enable_mask;
  logic              i_ch_done;
  logic              i_clear_overrun;
  logic [DATA_W-1:0] o_sample;
  logic [CH_W-1:0]   o_ch_index;
  logic              o_ch_start;
  logic              o_frame_done;
  logic              o_active;
  logic              o_overrun;
  logic              o_timeout;

  always #5 clk = ~clk;

  wavelet_channel_sequencer #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .i_data_clk(i_data_clk), .i_value(i_value),
    .i_enable_mask(i_enable_mask), .i_ch_done(i_ch_done),
    .i_clear_overrun(i_clear_overrun), .o_sample(o_sample),
    .o_ch_index(o_ch_index), .o_ch_start(o_ch_start),
    .o_frame_done(o_frame_done), .o_active(o_active),
    .o_overrun(o_overrun), .o_timeout(o_timeout)
  );

  // Reference model
  localparam int MP_IDLE = 0, MP_START = 1, MP_WAIT = 2, MP_NEXT = 3, MP_DONE = 4;
  int         m_phase = MP_IDLE;
  int         m_pend[$];
  int         m_cur = 0;
  int         m_waited = 0;
  bit         m_hist[3] = '{1'b1, 1'b1, 1'b1};
  logic [7:0] m_sample = 8'h00;
  bit         m_ovr = 1'b0;
  bit         m_to = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int log_ch[$];
  int log_cyc[$];
  int fd_cnt = 0;
  int fd_cyc = -1;
  int to_cyc = -1;
  bit to_seen = 1'b0;
  int resp = 0;
  int cd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int at_ch(input int i);
    return (log_ch.size() > i) ? log_ch[i] : -1;
  endfunction

  function automatic int at_cyc(input int i);
    return (log_cyc.size() > i) ? log_cyc[i] : -1;
  endfunction

  task automatic clear_log();
    log_ch.delete();
    log_cyc.delete();
    fd_cnt  = 0;
    fd_cyc  = -1;
    to_cyc  = -1;
    to_seen = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs seen at that edge.
  task automatic model_update();
    bit edge_now;
    bit ovr_set;
    bit to_set;
    if (rst) begin
      m_phase  = MP_IDLE;
      m_pend.delete();
      m_cur    = 0;
      m_waited = 0;
      m_sample = 8'h00;
      m_ovr    = 1'b0;
      m_to     = 1'b0;
      m_hist   = '{1'b1, 1'b1, 1'b1};
    end else begin
      edge_now  = m_hist[1] && !m_hist[2];
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = i_data_clk;
      ovr_set   = edge_now && (m_phase != MP_IDLE);
      to_set    = 1'b0;
      case (m_phase)
        MP_IDLE: begin
          if (edge_now) begin
            m_sample = i_value;
            m_pend.delete();
            for (int b = 0; b < NUM_CH; b++) begin
              if (i_enable_mask[b]) m_pend.push_back(b);
            end
            if (m_pend.size() > 0) begin
              m_cur   = m_pend.pop_front();
              m_phase = MP_START;
            end else begin
              m_phase = MP_DONE;
            end
          end
        end
        MP_START: begin
          m_phase  = MP_WAIT;
          m_waited = 0;
        end
        MP_WAIT: begin
          m_waited++;
          if (i_ch_done) begin
            m_phase = MP_NEXT;
          end else if (m_waited == TIMEOUT) begin
            to_set  = 1'b1;
            m_phase = MP_NEXT;
          end
        end
        MP_NEXT: begin
          if (m_pend.size() > 0) begin
            m_cur   = m_pend.pop_front();
            m_phase = MP_START;
          end else begin
            m_phase = MP_DONE;
          end
        end
        MP_DONE: m_phase = MP_IDLE;
        default: m_phase = MP_IDLE;
      endcase
      if (ovr_set) m_ovr = 1'b1;
      else if (i_clear_overrun) m_ovr = 1'b0;
      if (to_set) m_to = 1'b1;
      else if (i_clear_overrun) m_to = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    chk("sample",     32'(o_sample),     32'(m_sample));
    chk("ch_index",   32'(o_ch_index),   32'(m_cur));
    chk("ch_start",   32'(o_ch_start),   32'(m_phase == MP_START));
    chk("frame_done", 32'(o_frame_done), 32'(m_phase == MP_DONE));
    chk("active",     32'(o_active),     32'(m_phase != MP_IDLE));
    chk("overrun",    32'(o_overrun),    32'(m_ovr));
    chk("timeout",    32'(o_timeout),    32'(m_to));
  endtask

  // One clock: update model at the edge, compare 1 time unit later, then
  // log events and drive the engine's completion pulse for the next edge.
  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    compare_outputs();
    if (o_ch_start) begin
      log_ch.push_back(int'(o_ch_index));
      log_cyc.push_back(cyc);
    end
    if (o_frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (o_timeout && !to_seen) begin
      to_seen = 1'b1;
      to_cyc  = cyc;
    end
    i_ch_done = 1'b0;
    if (rst) cd = 0;
    else if (resp > 0 && o_ch_start) cd = resp;
    if (cd > 0) begin
      cd--;
      if (cd == 0) i_ch_done = 1'b1;
    end
  endtask

  // Strobe high for four edges; n_edge is the first edge that samples it high.
  task automatic strobe(input logic [7:0] val, input logic [7:0] msk, output int n_edge);
    i_value       = val;
    i_enable_mask = msk;
    i_data_clk    = 1'b1;
    n_edge        = cyc + 1;
    repeat (4) step();
    i_data_clk = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int i = 0; i < limit && (o_active || m_phase != MP_IDLE); i++) step();
    chk(name, 32'(o_active), 32'd0);
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int n2;
    rst             = 1'b1;
    i_data_clk      = 1'b0;
    i_value         = 8'h00;
    i_enable_mask   = 8'h00;
    i_ch_done       = 1'b0;
    i_clear_overrun = 1'b0;
    repeat (3) step();
    chk("rst_sample",  32'(o_sample), 32'h0);
    chk("rst_index",   32'(o_ch_index), 32'h0);
    chk("rst_active",  32'(o_active), 32'h0);
    chk("rst_flags",   32'({o_ch_start, o_frame_done, o_overrun, o_timeout}), 32'h0);
    rst = 1'b0;
    repeat (3) step();

    // Two-channel frame, engine answers 3 cycles after each start.
    clear_log();
    resp = 3;
    strobe(8'hA5, 8'b0000_0101, n);
    wait_idle("s1_idle", 100);
    chk("s1_nstarts",     32'(log_ch.size()), 32'd2);
    chk("s1_first_ch",    32'(at_ch(0)), 32'd0);
    chk("s1_second_ch",   32'(at_ch(1)), 32'd2);
    chk("s1_start_cycle", 32'(at_cyc(0)), 32'(n + 2));
    chk("s1_sample",      32'(o_sample), 32'hA5);
    chk("s1_frame_done",  32'(fd_cnt), 32'd1);
    chk("s1_active",      32'(o_active), 32'd0);

    // Silent engine on ch 7; mask change mid-frame must be ignored.
    clear_log();
    resp = 0;
    strobe(8'h3C, 8'h80, n);
    i_enable_mask = 8'hFF;
    wait_idle("s2_idle", 100);
    chk("s2_nstarts",    32'(log_ch.size()), 32'd1);
    chk("s2_ch",         32'(at_ch(0)), 32'd7);
    chk("s2_timeout",    32'(o_timeout), 32'd1);
    chk("s2_to_delay",   32'(to_cyc - at_cyc(0)), 32'd17);
    chk("s2_frame_done", 32'(fd_cnt), 32'd1);
    i_clear_overrun = 1'b1;
    step();
    i_clear_overrun = 1'b0;
    chk("s2_to_clear",   32'(o_timeout), 32'd0);

    // Second strobe edge during WAIT is dropped and flagged.
    clear_log();
    resp = 10;
    strobe(8'h11, 8'h01, n);
    step();
    step();
    strobe(8'h22, 8'hFF, n2);
    wait_idle("s3_idle", 100);
    chk("s3_overrun",    32'(o_overrun), 32'd1);
    chk("s3_sample",     32'(o_sample), 32'h11);
    chk("s3_nstarts",    32'(log_ch.size()), 32'd1);
    chk("s3_frame_done", 32'(fd_cnt), 32'd1);
    i_clear_overrun = 1'b1;
    step();
    i_clear_overrun = 1'b0;
    chk("s3_ovr_clear",  32'(o_overrun), 32'd0);

    // Empty mask: frame closes immediately, engine untouched.
    clear_log();
    strobe(8'h5A, 8'h00, n);
    wait_idle("s4_idle", 50);
    chk("s4_nstarts",  32'(log_ch.size()), 32'd0);
    chk("s4_fd_count", 32'(fd_cnt), 32'd1);
    chk("s4_fd_cycle", 32'(fd_cyc), 32'(n + 2));
    chk("s4_sample",   32'(o_sample), 32'h5A);

    // Completion on the 16th WAIT cycle: no timeout.
    clear_log();
    resp = 17;
    strobe(8'h77, 8'h08, n);
    wait_idle("s5_idle", 100);
    chk("s5_timeout",  32'(o_timeout), 32'd0);
    chk("s5_ch",       32'(at_ch(0)), 32'd3);
    chk("s5_fd_delay", 32'(fd_cyc - at_cyc(0)), 32'd18);
    chk("s5_fd_count", 32'(fd_cnt), 32'd1);

    // Reset in WAIT with strobe held high across release.
    clear_log();
    resp = 0;
    strobe(8'h99, 8'h06, n);
    repeat (3) step();
    rst        = 1'b1;
    i_data_clk = 1'b1;
    step();
    chk("s6_rst_outs", 32'({o_sample, 1'b0, o_ch_index, o_ch_start, o_frame_done,
                            o_active, o_overrun, o_timeout}), 32'h0);
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("s6_no_frame",  32'(fd_cnt), 32'd0);
    chk("s6_nstarts",   32'(log_ch.size()), 32'd1);
    chk("s6_active",    32'(o_active), 32'd0);
    i_data_clk = 1'b0;
    step();
    step();
    clear_log();
    resp = 2;
    strobe(8'h44, 8'h02, n);
    wait_idle("s6_idle", 100);
    chk("s6_new_ch",     32'(at_ch(0)), 32'd1);
    chk("s6_new_sample", 32'(o_sample), 32'h44);
    chk("s6_new_fd",     32'(fd_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wavelet_channel_sequencer.md
WAVELET_CHANNEL_SEQUENCER -- requirements
Module: wavelet_channel_sequencer

Interface
REQ-001 Parameter DATA_W, 8, sample width.
REQ-002 Parameter NUM_CH, 8, number of wavelet channels sharing one filter engine.
REQ-003 Parameter CH_W, 3, channel index width; CH_W SHALL equal clog2(NUM_CH).
REQ-004 Parameter TIMEOUT, 16, maximum WAIT cycles per channel.
REQ-005 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-006 clk  in  1  sole clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 i_data_clk  in  1  asynchronous sample strobe from pad.
REQ-009 i_value  in  DATA_W  pad sample data.
REQ-010 i_enable_mask  in  NUM_CH  bit n set = process channel n.
REQ-011 i_ch_done  in  1  one-cycle completion pulse from the filter engine.
REQ-012 i_clear_overrun  in  1  clears o_overrun and o_timeout.
REQ-013 o_sample  out  DATA_W  captured sample held for the frame.
REQ-014 o_ch_index  out  CH_W  channel currently scheduled.
REQ-015 o_ch_start  out  1  one-cycle start pulse to the engine.
REQ-016 o_frame_done  out  1  one-cycle pulse at end of frame.
REQ-017 o_active  out  1  high whenever state != IDLE.
REQ-018 o_overrun  out  1  sticky: strobe edge dropped.
REQ-019 o_timeout  out  1  sticky: a channel missed i_ch_done.

Function
REQ-020 i_data_clk SHALL pass through a 3-flop chain s1->s2->s3; edge = s2 & ~s3.
REQ-021 FSM states SHALL be IDLE, START, WAIT, NEXT, DONE.
REQ-022 IDLE, edge: capture i_value into o_sample and i_enable_mask into an internal mask at the same clock edge; go START with o_ch_index = lowest set bit; mask == 0 goes DONE.
REQ-023 Strobe high before edge N: s2 rises at edge N+1, IDLE->START at edge N+2, o_ch_start high during cycle N+2..N+3.
REQ-024 START: o_ch_start = 1 for exactly one cycle; next state WAIT; timer cleared to 0.
REQ-025 WAIT: timer increments each cycle; i_ch_done -> NEXT; timer == TIMEOUT-1 without i_ch_done -> set o_timeout, go NEXT.
REQ-026 i_ch_done and timer expiry in the same cycle: done wins, o_timeout unchanged.
REQ-027 NEXT: lowest latched-mask bit above o_ch_index -> o_ch_index, go START; none -> DONE; o_ch_index never wraps within a frame.
REQ-028 DONE: o_frame_done = 1 for one cycle, go IDLE; o_ch_index holds last value.
REQ-029 An edge in any state other than IDLE SHALL be dropped and set o_overrun; o_sample and the mask are unchanged.
REQ-030 i_ch_done outside WAIT SHALL be ignored.
REQ-031 i_clear_overrun clears both sticky flags; a set event in the same cycle wins.
REQ-032 Mask changes during a frame SHALL have no effect until the next capture.
REQ-033 o_ch_start, o_frame_done are registered outputs; o_active is registered or state-decoded, glitch-free.

Reset
REQ-034 rst SHALL force IDLE, o_sample = 0, o_ch_index = 0, all pulse and sticky outputs = 0, timer = 0, mask = 0.
REQ-035 rst SHALL load s1..s3 = 1, so a strobe held high across reset release is not an edge.
REQ-036 rst mid-frame SHALL abort without o_frame_done; the next frame starts only on a fresh low->high strobe.

Verification
REQ-037 mask = 8'b0000_0101, i_value = 8'hA5, engine done 3 cycles after each start -> o_sample = A5, starts on ch 0 then ch 2, one o_frame_done, o_active low after.
REQ-038 mask = 8'h80, engine never responds -> ch 7 start, o_timeout set after 16 WAIT cycles, o_frame_done pulses.
REQ-039 Second strobe edge during WAIT -> o_overrun = 1, o_sample unchanged; i_clear_overrun -> 0 next cycle.
REQ-040 mask = 8'h00 with strobe -> no o_ch_start, o_frame_done one cycle after leaving IDLE.
REQ-041 i_ch_done on the 16th WAIT cycle -> no timeout; rst asserted in WAIT -> all outputs 0, no o_frame_done.
REQ-042 i_data_clk held high through reset release -> no frame until low then high again.
